// File: rtl/usr_axis_rx_fifo_if.sv
// AXI4-Stream beat bundle between an upstream source and the rx FIFO.
interface usr_axis_rx_fifo_if #(
   parameter int C_S_AXIS_TDATA_WIDTH = 32
);
   logic [C_S_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata;
   logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb;
   logic                              s00_axis_tlast;
   logic                              s00_axis_tvalid;
   logic                              s00_axis_tready;

   modport master (
      output s00_axis_tdata,
      output s00_axis_tstrb,
      output s00_axis_tlast,
      output s00_axis_tvalid,
      input  s00_axis_tready
   );

   modport slave (
      input  s00_axis_tdata,
      input  s00_axis_tstrb,
      input  s00_axis_tlast,
      input  s00_axis_tvalid,
      output s00_axis_tready
   );
endinterface

// File: rtl/usr_axis_rx_fifo.sv
// AXI4-Stream receive FIFO (first-word fall-through) with packet
// framing statistics and a sticky oversize-packet flag.
module usr_axis_rx_fifo #(
   parameter int C_S_AXIS_TDATA_WIDTH = 32,
   parameter int C_FIFO_DEPTH         = 16,
   parameter int C_MAX_PKT_BEATS      = 256
) (
   input  logic                              s00_axis_aclk,
   input  logic                              s00_axis_areset,
   usr_axis_rx_fifo_if.slave                 s_axis,
   input  logic                              usr_rd_en,
   output logic [C_S_AXIS_TDATA_WIDTH-1:0]   usr_rd_data,
   output logic                              usr_rd_last,
   output logic                              usr_empty,
   output logic                              usr_full,
   output logic [$clog2(C_FIFO_DEPTH):0]     fifo_level,
   output logic                              pkt_done,
   output logic [15:0]                       pkt_len,
   output logic [31:0]                       pkt_count,
   output logic                              err_oversize,
   input  logic                              err_clr
);
   localparam int AW = $clog2(C_FIFO_DEPTH);
   localparam int DW = C_S_AXIS_TDATA_WIDTH;
   localparam logic [AW:0] FULL_LVL = (AW+1)'(C_FIFO_DEPTH);
   localparam logic [31:0] MAX_BEATS = 32'(C_MAX_PKT_BEATS);

   typedef enum logic {IDLE, RECV} state_e;

   logic [DW:0]   mem_q [C_FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          full, empty, tready;
   logic          push, pop, tlast;
   logic [DW:0]   head;

   state_e        state_q;
   logic [15:0]   beat_cnt_q;
   logic [15:0]   beat_base, beat_inc;
   logic          pkt_done_q, err_q, err_set;
   logic [15:0]   pkt_len_q;
   logic [31:0]   pkt_count_q;
   logic          unused_tstrb;

   assign unused_tstrb = ^s_axis.s00_axis_tstrb;

   assign full   = (level_q == FULL_LVL);
   assign empty  = (level_q == '0);
   assign tready = ~full & ~s00_axis_areset;
   assign s_axis.s00_axis_tready = tready;

   assign tlast = s_axis.s00_axis_tlast;
   assign push  = s_axis.s00_axis_tvalid & tready;
   assign pop   = usr_rd_en & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge s00_axis_aclk) begin
      if (s00_axis_areset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage is not reset; outputs are masked while empty instead.
   always_ff @(posedge s00_axis_aclk) begin
      if (push) mem_q[wr_ptr_q] <= {tlast, s_axis.s00_axis_tdata};
   end

   assign head        = mem_q[rd_ptr_q];
   assign usr_rd_data = empty ? '0 : head[DW-1:0];
   assign usr_rd_last = ~empty & head[DW];
   assign usr_empty   = empty;
   assign usr_full    = full;
   assign fifo_level  = level_q;

   assign beat_base = (state_q == IDLE) ? 16'd0 : beat_cnt_q;
   assign beat_inc  = (beat_base == 16'hFFFF) ? beat_base
                                              : beat_base + 16'd1;
   assign err_set   = push & ~tlast & ({16'd0, beat_inc} == MAX_BEATS);

   always_ff @(posedge s00_axis_aclk) begin
      if (s00_axis_areset) begin
         state_q     <= IDLE;
         beat_cnt_q  <= '0;
         pkt_done_q  <= 1'b0;
         pkt_len_q   <= '0;
         pkt_count_q <= '0;
         err_q       <= 1'b0;
      end else begin
         pkt_done_q <= 1'b0;
         if (err_set)      err_q <= 1'b1;
         else if (err_clr) err_q <= 1'b0;
         if (push) begin
            if (tlast) begin
               state_q     <= IDLE;
               beat_cnt_q  <= '0;
               pkt_done_q  <= 1'b1;
               pkt_len_q   <= beat_inc;
               pkt_count_q <= pkt_count_q + 32'd1;
            end else begin
               state_q    <= RECV;
               beat_cnt_q <= beat_inc;
            end
         end
      end
   end

   assign pkt_done     = pkt_done_q;
   assign pkt_len      = pkt_len_q;
   assign pkt_count    = pkt_count_q;
   assign err_oversize = err_q;
endmodule

// File: tb/tb_usr_axis_rx_fifo.sv
// Directed bench for usr_axis_rx_fifo (depth 16, max packet 8 beats).
module tb_usr_axis_rx_fifo;
   localparam int DW = 32;
   localparam int DEPTH = 16;
   localparam int MAXB = 8;

   logic        clk = 1'b0;
   logic        areset = 1'b1;
   logic        rd_en = 1'b0;
   logic        err_clr = 1'b0;
   logic [DW-1:0] rd_data;
   logic        rd_last, empty, full, done, err;
   logic [4:0]  level;
   logic [15:0] plen;
   logic [31:0] pcount;

   int checks = 0;
   int errors = 0;

   usr_axis_rx_fifo_if #(.C_S_AXIS_TDATA_WIDTH(DW)) s_axis ();

   usr_axis_rx_fifo #(
      .C_S_AXIS_TDATA_WIDTH(DW),
      .C_FIFO_DEPTH(DEPTH),
      .C_MAX_PKT_BEATS(MAXB)
   ) dut (
      .s00_axis_aclk(clk),
      .s00_axis_areset(areset),
      .s_axis(s_axis),
      .usr_rd_en(rd_en),
      .usr_rd_data(rd_data),
      .usr_rd_last(rd_last),
      .usr_empty(empty),
      .usr_full(full),
      .fifo_level(level),
      .pkt_done(done),
      .pkt_len(plen),
      .pkt_count(pcount),
      .err_oversize(err),
      .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [DW-1:0] d, input logic l);
      s_axis.s00_axis_tvalid = 1'b1;
      s_axis.s00_axis_tdata  = d;
      s_axis.s00_axis_tlast  = l;
      tick();
      s_axis.s00_axis_tvalid = 1'b0;
   endtask

   task automatic pop_chk(input string tag, input logic [DW-1:0] d,
                          input logic l);
      chk({tag, "_data"}, 64'(rd_data), 64'(d));
      chk({tag, "_last"}, 64'(rd_last), 64'(l));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   initial begin
      int acc;
      int idx;
      logic a;
      s_axis.s00_axis_tvalid = 1'b0;
      s_axis.s00_axis_tdata  = '0;
      s_axis.s00_axis_tstrb  = '1;
      s_axis.s00_axis_tlast  = 1'b0;

      tick();
      tick();
      chk("rst_tready", 64'(s_axis.s00_axis_tready), 0);
      chk("rst_empty", 64'(empty), 1);
      chk("rst_full", 64'(full), 0);
      chk("rst_level", 64'(level), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_len", 64'(plen), 0);
      chk("rst_count", 64'(pcount), 0);
      chk("rst_err", 64'(err), 0);
      chk("rst_data", 64'(rd_data), 0);
      chk("rst_last", 64'(rd_last), 0);
      areset = 1'b0;
      #1;
      chk("post_rst_tready", 64'(s_axis.s00_axis_tready), 1);

      // single 4-beat packet
      beat(32'h11, 1'b0);
      chk("lat_empty", 64'(empty), 0);
      chk("lat_head", 64'(rd_data), 64'h11);
      beat(32'h22, 1'b0);
      beat(32'h33, 1'b0);
      chk("s1_nodone", 64'(done), 0);
      beat(32'h44, 1'b1);
      chk("s1_done", 64'(done), 1);
      chk("s1_len", 64'(plen), 4);
      chk("s1_count", 64'(pcount), 1);
      chk("s1_level", 64'(level), 4);
      chk("s1_head", 64'(rd_data), 64'h11);
      chk("s1_hlast", 64'(rd_last), 0);
      tick();
      chk("s1_pulse", 64'(done), 0);
      chk("s1_lenhold", 64'(plen), 4);
      pop_chk("s1_p0", 32'h11, 1'b0);
      pop_chk("s1_p1", 32'h22, 1'b0);
      pop_chk("s1_p2", 32'h33, 1'b0);
      pop_chk("s1_p3", 32'h44, 1'b1);
      chk("s1_drained", 64'(empty), 1);

      // pop when empty
      rd_en = 1'b1;
      tick();
      tick();
      rd_en = 1'b0;
      chk("pe_level", 64'(level), 0);
      chk("pe_empty", 64'(empty), 1);

      // fill and backpressure: 20 single-beat packets offered
      acc = 0;
      idx = 0;
      for (int i = 0; i < 20; i++) begin
         s_axis.s00_axis_tvalid = 1'b1;
         s_axis.s00_axis_tlast  = 1'b1;
         s_axis.s00_axis_tdata  = 32'h100 + 32'(idx);
         a = s_axis.s00_axis_tready;
         tick();
         if (a) begin
            acc++;
            idx++;
         end
      end
      chk("fill_acc", 64'(acc), 16);
      chk("fill_tready", 64'(s_axis.s00_axis_tready), 0);
      chk("fill_full", 64'(full), 1);
      chk("fill_level", 64'(level), 16);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("fill_pop_level", 64'(level), 15);
      acc = 0;
      for (int i = 0; i < 4; i++) begin
         s_axis.s00_axis_tdata = 32'h100 + 32'(idx);
         a = s_axis.s00_axis_tready;
         tick();
         if (a) begin
            acc++;
            idx++;
         end
      end
      s_axis.s00_axis_tvalid = 1'b0;
      chk("fill_one_more", 64'(acc), 1);
      chk("fill_full2", 64'(full), 1);
      for (int i = 1; i <= 16; i++)
         pop_chk("fill_pop", 32'h100 + 32'(i), 1'b1);
      chk("fill_count", 64'(pcount), 18);

      // simultaneous push/pop at level 5
      for (int i = 0; i < 5; i++) beat(32'h200 + 32'(i), 1'b1);
      chk("pp_level5", 64'(level), 5);
      rd_en = 1'b1;
      beat(32'h205, 1'b1);
      rd_en = 1'b0;
      chk("pp_level", 64'(level), 5);
      for (int i = 1; i <= 5; i++)
         pop_chk("pp_pop", 32'h200 + 32'(i), 1'b1);
      chk("pp_count", 64'(pcount), 24);

      // oversize: 10 beats then tlast, continuous reads
      rd_en = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         beat(32'h300 + 32'(i), 1'b0);
         if (i == 7) chk("ov_err7", 64'(err), 0);
         if (i == 8) chk("ov_err8", 64'(err), 1);
      end
      beat(32'h30B, 1'b1);
      chk("ov_done", 64'(done), 1);
      chk("ov_len", 64'(plen), 11);
      chk("ov_count", 64'(pcount), 25);
      chk("ov_head", 64'(rd_data), 64'h30B);
      tick();
      rd_en = 1'b0;
      chk("ov_sticky", 64'(err), 1);
      chk("ov_empty", 64'(empty), 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("ov_clr", 64'(err), 0);

      // reset mid-packet
      beat(32'h401, 1'b0);
      beat(32'h402, 1'b0);
      beat(32'h403, 1'b0);
      chk("rm_level", 64'(level), 3);
      areset = 1'b1;
      tick();
      chk("rm_rst_done", 64'(done), 0);
      areset = 1'b0;
      #1;
      chk("rm_empty", 64'(empty), 1);
      chk("rm_count", 64'(pcount), 0);
      tick();
      chk("rm_nodone", 64'(done), 0);
      beat(32'h500, 1'b1);
      chk("rm_len", 64'(plen), 1);
      chk("rm_done", 64'(done), 1);
      chk("rm_count1", 64'(pcount), 1);
      chk("rm_head", 64'(rd_data), 64'h500);
      chk("rm_hlast", 64'(rd_last), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
